gauss_stream_ctrl: RTL and testbench

- AXI4-Stream sequencer for the 3x3 Gaussian line-buffer convolution engine.
- Converts the valid/ready handshake into the engine's single `stall` control.
- Injects flush beats at end of frame so the last row emerges, discards the engine's warm-up beats, and regenerates tuser/tlast on the output.
- Sits between the DMA input stream and the fusion pipeline; owns the engine's reset between frames.

---
 rtl/gauss_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gauss_stream_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_stream_ctrl.sv
// AXI4-Stream sequencer for the 3x3 Gaussian line-buffer engine: handshake -> stall, end-of-frame flush, warm-up discard, tuser/tlast regeneration.
// Latency ENG_LATENCY advances + 1 capture cycle + skid FIFO; output backpressure stalls the engine via FIFO space. Optional GAUSS_CTRL_PERF_EN adds perf counters.
module gauss_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
  parameter int ENG_LATENCY     = IMAGE_DIM/PIXELS_PER_BEAT+1,
  parameter int OFIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  eng_aresetn,
  output logic                  eng_stall,
  output logic [DATA_WIDTH-1:0] eng_inp_frame,
  input  logic [DATA_WIDTH-1:0] eng_out_frame,
  output logic                  frame_err
`ifdef GAUSS_CTRL_PERF_EN
  ,
  output logic [31:0]           in_stall_cnt,
  output logic [31:0]           out_bp_cnt,
  output logic [31:0]           frame_cnt
`endif
);

  localparam int BPR = IMAGE_DIM/PIXELS_PER_BEAT;
  localparam int F   = BPR*IMAGE_DIM;
  localparam int AW  = $clog2(F+ENG_LATENCY);
  localparam int IW  = (F > 1) ? $clog2(F) : 1;
  localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int PW  = $clog2(OFIFO_DEPTH);
  localparam int OCW = $clog2(OFIFO_DEPTH+1);
  localparam logic [AW-1:0]  A_LAST = AW'(F+ENG_LATENCY-1);
  localparam logic [AW-1:0]  A_LAT  = AW'(ENG_LATENCY);
  localparam logic [IW-1:0]  I_LAST = IW'(F-1);
  localparam logic [CW-1:0]  C_LAST = CW'(BPR-1);
  localparam logic [OCW:0]   SP_MAX = (OCW+1)'(OFIFO_DEPTH-2);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STREAM, S_FLUSH, S_DRAIN} state_t;

  state_t                state;
  logic [AW-1:0]         a_cnt;
  logic [IW-1:0]         i_cnt;
  logic [CW-1:0]         i_col;
  logic [IW-1:0]         o_cnt;
  logic [CW-1:0]         o_col;
  logic                  cap_pend;
  logic [DATA_WIDTH-1:0] fifo_mem [OFIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OCW-1:0]        fifo_cnt;
  logic                  in_stream;
  logic                  space;
  logic                  adv;
  logic                  pop;
  logic                  drain_done;
  logic [OCW:0]          occ;

  // A capture is already committed one cycle ahead, so it counts against space.
  assign occ        = {1'b0, fifo_cnt} + {{OCW{1'b0}}, cap_pend};
  assign space      = (occ <= SP_MAX);
  assign in_stream  = (state == S_STREAM);
  assign adv        = (in_stream & s_axis_tvalid & space) | ((state == S_FLUSH) & space);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign drain_done = (fifo_cnt == '0) & ~cap_pend;

  assign s_axis_tready = (in_stream & space) | ((state == S_WAIT) & ~s_axis_tuser);
  assign eng_stall     = ~adv;
  assign eng_inp_frame = in_stream ? s_axis_tdata : '0;

  assign m_axis_tvalid = (fifo_cnt != '0);
  assign m_axis_tdata  = fifo_mem[rd_ptr];
  assign m_axis_tuser  = m_axis_tvalid & (o_cnt == '0);
  assign m_axis_tlast  = m_axis_tvalid & (o_col == C_LAST);

  always_ff @(posedge clk) begin
    if (cap_pend) fifo_mem[wr_ptr] <= eng_out_frame;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (cap_pend) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (cap_pend && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!cap_pend && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      eng_aresetn <= 1'b0;
      a_cnt       <= '0;
      i_cnt       <= '0;
      i_col       <= '0;
      o_cnt       <= '0;
      o_col       <= '0;
      cap_pend    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // The first ENG_LATENCY advances only fill the line buffers.
      cap_pend <= adv && (a_cnt >= A_LAT);
      if (adv) a_cnt <= (a_cnt == A_LAST) ? '0 : a_cnt + 1'b1;
      if (pop) begin
        o_cnt <= (o_cnt == I_LAST) ? '0 : o_cnt + 1'b1;
        o_col <= (o_col == C_LAST) ? '0 : o_col + 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          eng_aresetn <= 1'b1;
          state       <= S_WAIT;
          a_cnt       <= '0;
          i_cnt       <= '0;
          i_col       <= '0;
          o_cnt       <= '0;
          o_col       <= '0;
        end
        S_WAIT: begin
          if (s_axis_tvalid) begin
            if (s_axis_tuser) state <= S_STREAM;
            else              frame_err <= 1'b1;
          end
        end
        S_STREAM: begin
          if (adv) begin
            if (s_axis_tlast != (i_col == C_LAST)) frame_err <= 1'b1;
            if (s_axis_tuser && (i_cnt != '0))     frame_err <= 1'b1;
            i_col <= (i_col == C_LAST) ? '0 : i_col + 1'b1;
            i_cnt <= i_cnt + 1'b1;
            if (i_cnt == I_LAST) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (adv && (a_cnt == A_LAST)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state       <= S_IDLE;
            eng_aresetn <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GAUSS_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      in_stall_cnt <= '0;
      out_bp_cnt   <= '0;
      frame_cnt    <= '0;
    end else begin
      if (in_stream && !s_axis_tvalid && (in_stall_cnt != '1)) in_stall_cnt <= in_stall_cnt + 1'b1;
      if (m_axis_tvalid && !m_axis_tready && (out_bp_cnt != '1)) out_bp_cnt <= out_bp_cnt + 1'b1;
      if ((state == S_DRAIN) && drain_done && (frame_cnt != '1)) frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gauss_stream_ctrl.sv
// Bench for gauss_stream_ctrl at IMAGE_DIM=64, 16 pixels/beat, with a delay-line engine stand-in and a scoreboard queue.
module tb_gauss_stream_ctrl;
  localparam int PPB = 16;
  localparam int DIM = 64;
  localparam int DW  = 128;
  localparam int BPR = 4;
  localparam int F   = 256;
  localparam int L   = 5;
  localparam logic [DW-1:0] XPAT = {16{8'h5A}};

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          eng_aresetn;
  logic          eng_stall;
  logic [DW-1:0] eng_inp_frame;
  logic [DW-1:0] eng_out_frame;
  logic          frame_err;

  gauss_stream_ctrl #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW),
                      .ENG_LATENCY(L), .OFIFO_DEPTH(4)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .eng_aresetn(eng_aresetn), .eng_stall(eng_stall), .eng_inp_frame(eng_inp_frame),
    .eng_out_frame(eng_out_frame), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Engine stand-in: beat k leaves the registered output after advance k+L.
  logic [DW-1:0] pipe [0:L];
  always @(posedge clk) begin
    if (!eng_aresetn) begin
      for (int i = 0; i <= L; i++) pipe[i] <= '0;
    end else if (!eng_stall) begin
      pipe[0] <= eng_inp_frame;
      for (int i = 1; i <= L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign eng_out_frame = pipe[L] ^ XPAT;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  int rdy_mode = 0;
  int in_cnt   = 0;
  int out_idx  = 0;
  int out_total = 0;
  int pulses = 0, bad_runs = 0, low_run = 0;
  logic tainted = 1'b0;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_dat;
  logic [1:0] prev_ul;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_dat(input int seed, input int k);
    logic [DW-1:0] d;
    for (int j = 0; j < PPB; j++) d[j*8 +: 8] = 8'(seed + k*PPB + j);
    return d;
  endfunction

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 99) >= 30);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop, regenerated sideband, hold stability, engine reset pulses.
  always @(negedge clk) begin
    if (!eng_aresetn) begin
      low_run++;
      if (!aresetn) tainted = 1'b1;
    end else if (low_run > 0) begin
      if (!tainted) begin
        pulses++;
        if (low_run != 1) bad_runs++;
      end
      low_run = 0;
      tainted = 1'b0;
    end
    if (!aresetn) begin
      prev_hold = 1'b0;
      out_idx   = 0;
      out_total = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_vld", m_axis_tvalid, 1'b1);
        chk("hold_dat", m_axis_tdata, prev_dat);
        chk("hold_user_last", {m_axis_tuser, m_axis_tlast}, prev_ul);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: output beat %0d with no expected beat", out_total);
        end else begin
          chk("out_dat", m_axis_tdata, exp_q.pop_front());
        end
        chk("out_tuser", m_axis_tuser, out_idx == 0);
        chk("out_tlast", m_axis_tlast, (out_idx % BPR) == BPR-1);
        out_idx = (out_idx + 1) % F;
        out_total++;
      end
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_dat  = m_axis_tdata;
      prev_ul   = {m_axis_tuser, m_axis_tlast};
    end
  end

  task automatic check_rst(input string tag);
    chk({tag, "_s_tready"}, s_axis_tready, 1'b0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_m_tuser"}, m_axis_tuser, 1'b0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
    chk({tag, "_eng_stall"}, eng_stall, 1'b1);
    chk({tag, "_eng_aresetn"}, eng_aresetn, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  // Starts and ends at posedge+1; reset is sampled by exactly one clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check_rst(tag);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_beats(input int seed, input int gap_pct, input int bad, input int nb);
    logic hs, done, tl;
    for (int k = 0; k < nb; k++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      tl = ((k % BPR) == BPR-1);
      if (bad >= 0 && k == bad) tl = 1'b1;
      if (bad >= 0 && k == bad+1) tl = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_dat(seed, k);
      s_axis_tuser  = (k == 0);
      s_axis_tlast  = tl;
      done = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk); #1;
        if (hs) begin
          exp_q.push_back(beat_dat(seed, k) ^ XPAT);
          in_cnt++;
          done = 1'b1;
        end
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_handshake_timeout: beat %0d not accepted", k);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int c = 0; c < 6000 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d beats still expected", tag, exp_q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int   rdy_mode;
    int   gap_pct;
    int   bad_last;
    logic exp_err;
    int   exp_beats;
  } vec_t;
  vec_t vecs [3];

  initial begin
    int p0, b0;
    logic seen;
    vecs[0] = '{rdy_mode: 0, gap_pct: 0,  bad_last: -1, exp_err: 1'b0, exp_beats: F};
    vecs[1] = '{rdy_mode: 1, gap_pct: 30, bad_last: -1, exp_err: 1'b0, exp_beats: F};
    vecs[2] = '{rdy_mode: 0, gap_pct: 0,  bad_last: 2,  exp_err: 1'b1, exp_beats: F};

    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset("rst0");

    for (int v = 0; v < 3; v++) begin
      do_reset("vec_rst");
      rdy_mode = vecs[v].rdy_mode;
      send_beats(v*7, vecs[v].gap_pct, vecs[v].bad_last, F);
      wait_empty("vec");
      chk("vec_beats", out_total, vecs[v].exp_beats);
      chk("vec_frame_err", frame_err, vecs[v].exp_err);
      repeat (20) @(posedge clk);
      #1;
      chk("vec_frame_err_sticky", frame_err, vecs[v].exp_err);
      rdy_mode = 0;
    end

    // Output blocked for 50 cycles in the middle of a frame.
    do_reset("stall_rst");
    in_cnt = 0;
    fork
      send_beats(40, 0, -1, F);
      begin
        for (int c = 0; c < 2000 && in_cnt < 60; c++) begin
          @(posedge clk); #1;
        end
        rdy_mode = 2;
        @(posedge clk); #2;
        seen = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!s_axis_tready) seen = 1'b1;
        end
        chk("stall_tready_fall", seen, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        chk("stall_tready_held", s_axis_tready, 1'b0);
        chk("stall_out_valid", m_axis_tvalid, 1'b1);
        rdy_mode = 0;
      end
    join
    wait_empty("stall");
    chk("stall_beats", out_total, F);

    // Two back-to-back frames: one single-cycle engine reset after each.
    do_reset("b2b_rst");
    repeat (3) @(posedge clk);
    #1;
    p0 = pulses;
    b0 = bad_runs;
    send_beats(90, 0, -1, F);
    send_beats(150, 0, -1, F);
    wait_empty("b2b");
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_pulse_len", bad_runs - b0, 0);
    chk("b2b_beats", out_total, 2*F);
    chk("b2b_frame_err", frame_err, 1'b0);

    // Stray beat without tuser while waiting for a frame start.
    do_reset("wait_rst");
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = beat_dat(3, 0);
    @(negedge clk);
    chk("wait_drop_ready", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("wait_drop_err", frame_err, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("wait_drop_no_out", out_total, 0);

    // Reset pulse after 100 input beats, then a fresh frame.
    do_reset("mid_rst0");
    send_beats(200, 0, -1, 100);
    do_reset("mid_rst");
    send_beats(11, 0, -1, F);
    wait_empty("mid");
    chk("mid_beats", out_total, F);
    chk("mid_frame_err", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
